// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Integer register file for the pipelined RISC-V core. It has a per-register
// write-pending scoreboard. The issue stage reserves a destination register,
// and that sets its busy bit. Writeback stores the data and clears the bit.
// Decode reads the busy bits to detect RAW and WAW hazards.
//
// Parameters
//   XLEN      data width of each register
//   NREGS     number of registers (power of two, >= 4)
//   ZERO_REG  1: register 0 always reads 0, is never busy, and ignores writes
//   BYPASS    1: same-cycle write data and busy-clear are forwarded to reads
//
// Ports
//   clk                    clock, all state updates on the rising edge
//   rst_n                  asynchronous active-low reset
//   rd_addr1/2             read addresses
//   rd_data1/2             read data (combinational)
//   rd_busy1/2             scoreboard bit of the addressed register (comb.)
//   wr_en/wr_addr/wr_data  writeback port
//   rsv_en/rsv_addr        reservation request from issue
//   rsv_grant              reservation accepted this cycle (comb.)
//   flush                  clears every busy bit
//   busy_count             number of registers currently busy
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_grant,
    input  logic            flush,
    output logic [AW:0]     busy_count
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(NREGS);

    logic [XLEN-1:0]  data_q [NREGS];
    logic [XLEN-1:0]  data_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    logic wr_zero;      // write targets the hardwired zero register
    logic rsv_zero;     // reservation targets the hardwired zero register
    logic wr_hits_rsv;  // writeback and reservation address the same register
    logic rsv_sets;     // granted reservation that really sets a busy bit
    logic cnt_inc;
    logic cnt_dec;

    // ------------------------------------------------------------------
    // Reservation grant
    // A busy register is granted only while it is being written back in
    // the same cycle. This keeps at most one outstanding writer per
    // register.
    // ------------------------------------------------------------------
    always_comb begin
        wr_zero     = (ZERO_REG != 0) && (wr_addr == '0);
        rsv_zero    = (ZERO_REG != 0) && (rsv_addr == '0);
        wr_hits_rsv = wr_en && (wr_addr == rsv_addr);
        rsv_grant   = rst_n && rsv_en && !flush &&
                      (!busy_q[rsv_addr] || wr_hits_rsv);
        rsv_sets    = rsv_grant && !rsv_zero;
    end

    // ------------------------------------------------------------------
    // Next-state: data array, busy bits and busy counter
    // A granted reservation wins over a same-cycle writeback clear of the
    // same register. The data is stored and the bit stays set, so the
    // counter neither increments nor decrements for that register.
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        if (wr_en && !wr_zero) begin
            data_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wr_en && !wr_zero) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_sets) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_comb begin
        cnt_inc      = rsv_sets && !busy_q[rsv_addr];
        cnt_dec      = wr_en && !wr_zero && busy_q[wr_addr] &&
                       !(rsv_sets && wr_hits_rsv);
        busy_count_d = busy_count_q;
        if (flush) begin
            busy_count_d = '0;
        end else if (cnt_inc && !cnt_dec && (busy_count_q != CNT_MAX)) begin
            busy_count_d = busy_count_q + CNT_ONE;
        end else if (cnt_dec && !cnt_inc && (busy_count_q != '0)) begin
            busy_count_d = busy_count_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            data_q       <= data_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // ------------------------------------------------------------------
    // Read ports
    // The reset gate stops bypassed write data from showing on the read
    // ports while rst_n is low. Stored state is already zero in reset.
    // Result packing is {busy, data}.
    // ------------------------------------------------------------------
    function automatic logic [XLEN:0] read_mux(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored_data,
        input logic            stored_busy,
        input logic            in_reset
    );
        logic [XLEN:0] res;
        if (in_reset) begin
            res = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            res = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
            res = {1'b0, wr_data};
        end else begin
            res = {stored_busy, stored_data};
        end
        return res;
    endfunction

    always_comb begin
        {rd_busy1, rd_data1} = read_mux(rd_addr1, data_q[rd_addr1],
                                        busy_q[rd_addr1], !rst_n);
        {rd_busy2, rd_data2} = read_mux(rd_addr2, data_q[rd_addr2],
                                        busy_q[rd_addr2], !rst_n);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//
// Testbench for regfile_sb. It drives directed scenarios and then randomized
// traffic. All outputs are compared with a reference model that holds plain
// arrays: one array of register values and one array of busy flags. The
// model derives busy_count by counting the busy flags.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int ZERO_REG = 1;
    localparam int BYPASS   = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rd_addr1, rd_addr2;
    logic [XLEN-1:0] rd_data1, rd_data2;
    logic            rd_busy1, rd_busy2;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_grant;
    logic            flush;
    logic [AW:0]     busy_count;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rsv_grant  (rsv_grant),
        .flush      (flush),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit [XLEN-1:0] m_data [NREGS];
    bit            m_busy [NREGS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == 0);
    endfunction

    function automatic bit exp_grant();
        if (!rst_n || !rsv_en || flush) return 1'b0;
        return !m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr);
    endfunction

    task automatic exp_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
        if (!rst_n || is_zero_reg(a)) begin
            d = '0; b = 1'b0;
        end else if (BYPASS != 0 && wr_en && wr_addr == a) begin
            d = wr_data; b = 1'b0;
        end else begin
            d = m_data[a]; b = m_busy[a];
        end
    endtask

    // Checks every output at the falling edge, then advances the model
    // across the next rising edge. It returns at posedge + 1.
    task automatic step();
        logic [XLEN-1:0] d;
        logic            b;
        bit              g;
        @(negedge clk);
        exp_read(rd_addr1, d, b);
        chk("rd_data1", rd_data1, d);
        chk("rd_busy1", rd_busy1, b);
        exp_read(rd_addr2, d, b);
        chk("rd_data2", rd_data2, d);
        chk("rd_busy2", rd_busy2, b);
        g = exp_grant();
        chk("rsv_grant", rsv_grant, g);
        chk("busy_count", busy_count, model_count());
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (wr_en && !is_zero_reg(wr_addr)) begin
                m_data[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            end else if (g && !is_zero_reg(rsv_addr)) begin
                m_busy[rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "time limit reached");
    end

    initial begin
        rst_n = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0;
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        idle();
        model_clear();
        @(posedge clk);
        #1;

        // Reset: a write during reset is ignored and no data leaks out.
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1234_5678; rd_addr1 = 5;
        step();
        step();
        idle();
        rst_n = 1'b1;
        step();
        chk("rst_r5_data", rd_data1, 0);
        chk("rst_r5_busy", rd_busy1, 0);
        chk("rst_count", busy_count, 0);

        // Write and bypass.
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEAD_BEEF; rd_addr1 = 7;
        #1 chk("byp_same_cycle", rd_data1, 32'hDEAD_BEEF);
        step();
        idle();
        #1 chk("byp_after_edge", rd_data1, 32'hDEAD_BEEF);

        // Scoreboard reserve, refuse, and release.
        rsv_en = 1'b1; rsv_addr = 3; rd_addr1 = 3;
        #1 chk("sb_grant", rsv_grant, 1);
        step();
        idle();
        #1 chk("sb_busy", rd_busy1, 1);
        chk("sb_count1", busy_count, 1);
        rsv_en = 1'b1; rsv_addr = 3;
        #1 chk("sb_regrant", rsv_grant, 0);
        step();
        idle();
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
        step();
        idle();
        #1 chk("sb_clr_busy", rd_busy1, 0);
        chk("sb_clr_count", busy_count, 0);
        chk("sb_clr_data", rd_data1, 32'h55);

        // Same-cycle write and reservation of a busy register.
        rsv_en = 1'b1; rsv_addr = 3;
        step();
        idle();
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hAA; rsv_en = 1'b1; rsv_addr = 3;
        #1 chk("col_grant", rsv_grant, 1);
        step();
        idle();
        #1 chk("col_data", rd_data1, 32'hAA);
        chk("col_busy", rd_busy1, 1);
        chk("col_count", busy_count, 1);
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hAB;
        step();
        idle();

        // Zero register.
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 0; rd_addr1 = 0;
        #1 chk("zero_grant", rsv_grant, 1);
        step();
        idle();
        #1 chk("zero_data", rd_data1, 0);
        chk("zero_busy", rd_busy1, 0);
        chk("zero_count", busy_count, 0);

        // Flush.
        rsv_en = 1'b1;
        rsv_addr = 1; step();
        rsv_addr = 2; step();
        rsv_addr = 4; step();
        idle();
        #1 chk("fl_count3", busy_count, 3);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 6;
        #1 chk("fl_grant", rsv_grant, 0);
        step();
        idle();
        rd_addr1 = 1; rd_addr2 = 4;
        #1 chk("fl_count0", busy_count, 0);
        chk("fl_busy1", rd_busy1, 0);
        chk("fl_busy4", rd_busy2, 0);

        // Asynchronous reset in the middle of operation.
        rsv_en = 1'b1; rsv_addr = 5; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h9999;
        step();
        idle();
        rd_addr1 = 9; rd_addr2 = 5;
        #1 rst_n = 1'b0;
        #1 chk("arst_data", rd_data1, 0);
        chk("arst_busy", rd_busy2, 0);
        chk("arst_count", busy_count, 0);
        model_clear();
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int busy_list [$];
            busy_list = {};
            for (int i = 0; i < NREGS; i++) if (m_busy[i]) busy_list.push_back(i);
            wr_en    = ($urandom_range(0, 1) == 1);
            rsv_en   = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 29) == 0);
            wr_data  = $urandom;
            rsv_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                   : AW'($urandom);
            if (busy_list.size() > 0 && $urandom_range(0, 9) < 4)
                wr_addr = AW'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else if ($urandom_range(0, 3) == 0)
                wr_addr = rsv_addr;
            else
                wr_addr = AW'($urandom_range(0, 7));
            rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
            rd_addr2 = ($urandom_range(0, 2) == 0) ? rsv_addr : AW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_clear();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register write-pending scoreboard for the pipelined RISC-V core. It provides two asynchronous read ports and one synchronous write port. Register 0 can optionally be hardwired to zero, and write-to-read bypass is optional. Busy bits are reserved at issue and cleared at writeback, so the decode stage can detect RAW/WAW hazards and stall.

## Interface
- XLEN, 32: data width of each register.
- NREGS, 32: number of registers; power of two, at least 4; AW = log2(NREGS).
- ZERO_REG, 1: 1 hardwires register 0 to zero and makes it never busy; 0 makes it a normal register.
- BYPASS, 1: 1 forwards same-cycle write data and busy-clear to the read ports; 0 shows stored state only.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd_addr1, rd_addr2  input  AW  read addresses.
- rd_data1, rd_data2  output  XLEN  read data, combinational.
- rd_busy1, rd_busy2  output  1  scoreboard bit of the addressed register, combinational.
- wr_en  input  1  writeback strobe.
- wr_addr  input  AW  writeback address.
- wr_data  input  XLEN  writeback data.
- rsv_en  input  1  issue-stage request to reserve a destination register.
- rsv_addr  input  AW  register to reserve.
- rsv_grant  output  1  reservation accepted this cycle, combinational.
- flush  input  1  clears all busy bits (pipeline flush).
- busy_count  output  AW+1  number of currently busy registers.

## Operation
- Storage: NREGS x XLEN data array, NREGS busy bits, and a busy_count counter.
- Reset (rst_n low, asynchronous):
  - all data words = 0, all busy bits = 0, busy_count = 0;
  - rsv_grant forced 0 while rst_n is low;
  - rd_data = 0 and rd_busy = 0 for every address.
- Write: on a rising edge with wr_en = 1, data[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - With ZERO_REG = 1, a write to register 0 is discarded.
- Read, per port:
  - with ZERO_REG = 1 and address 0: data = 0, busy = 0;
  - otherwise, with BYPASS = 1 and wr_en = 1 and wr_addr equal to the read address: data = wr_data, busy = 0;
  - otherwise: stored data and stored busy bit.
- Reservation grant: rsv_grant = rsv_en and not flush and rst_n and (busy[rsv_addr] = 0, or wr_en = 1 with wr_addr equal to rsv_addr).
  - A register that is busy and not being written this cycle is refused, so there is at most one outstanding writer per register.
  - The requester must hold rsv_en until granted.
- Granted reservation: busy[rsv_addr] <= 1 at the edge.
  - This wins over a same-cycle write clear to the same address: the data is written and the bit stays set.
  - With ZERO_REG = 1, a reservation of register 0 is granted but sets no bit.
- Flush: on the edge, all busy bits <= 0 and busy_count <= 0.
  - rsv_grant is 0 during a flush cycle.
  - A write in the same cycle still updates data.
- busy_count: incremented by a grant that sets a bit that was clear, decremented by a write that clears a bit that was set.
  - Both events in the same cycle leave it unchanged.
  - The counter never wraps; its range is 0..NREGS.

## Timing
- Read latency: 0 cycles, combinational from addresses and from wr_* when BYPASS = 1.
- Write latency: 1 edge; with BYPASS = 0 the written value is visible from the cycle after the edge.
- rsv_grant: combinational in the request cycle; the busy bit is visible on the rd_busy ports from the next cycle.
- Asynchronous reset assertion mid-operation clears state immediately.
- Reset deassertion takes effect at the first rising edge after rst_n goes high.

## Test plan
- Reset: hold rst_n low, write 0x12345678 to register 5 -> after release, register 5 reads 0, rd_busy1 = 0, busy_count = 0.
- Write/bypass (BYPASS = 1): wr_en with register 7 = 0xDEADBEEF while rd_addr1 = 7 -> rd_data1 = 0xDEADBEEF in the same cycle, and still after the edge.
- Scoreboard: reserve register 3 -> grant 1, rd_busy 1, busy_count 1; re-request register 3 -> grant 0; write register 3 = 0x55 -> busy 0, count 0.
- Same-cycle collision: register 3 busy, write register 3 and reserve register 3 together -> grant 1, data = written value, bit stays 1, count unchanged.
- Zero register (ZERO_REG = 1): write 0xFFFFFFFF to register 0 and reserve register 0 -> reads 0, busy 0, grant 1, count unchanged.
- Flush: reserve registers 1, 2 and 4 -> count 3; assert flush together with a reserve of register 6 -> grant 0, all busy 0, count 0.
